// File: rtl/freq_gen.sv
// freq_gen: programmable test tone, N evenly spaced rising edges per window,
// with a self-reported rising-edge count for loopback against a meter.
module freq_gen #(
    parameter int WINDOW = 1000,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_count,
    output logic             fout,
    output logic             win_start,
    output logic [CNT_W-1:0] cnt_last,
    output logic             cnt_valid,
    output logic             sat
);

    localparam int ACC_W = $clog2(2 * WINDOW) + 1;
    localparam int WC_W  = $clog2(WINDOW);

    localparam logic [CNT_W-1:0] HALF  = CNT_W'(WINDOW / 2);
    localparam logic [ACC_W-1:0] WIN_A = ACC_W'(WINDOW);
    localparam logic [WC_W-1:0]  LAST  = WC_W'(WINDOW - 1);

    logic [WC_W-1:0]  win_cnt;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] sum;
    logic [CNT_W-1:0] target;
    logic [CNT_W-1:0] pending;
    logic [CNT_W-1:0] edge_cnt;
    logic [CNT_W-1:0] edge_nxt;
    logic [CNT_W-1:0] clamped;
    logic             pending_vld;
    logic             accept;
    logic             toggle;
    logic             rise;
    logic             boundary;

    assign cfg_ready = !pending_vld;
    assign accept    = cfg_valid && cfg_ready;
    assign clamped   = (cfg_count > HALF) ? HALF : cfg_count;

    assign win_start = enable && (win_cnt == '0);
    assign boundary  = enable && (win_cnt == LAST);

    // 2*target never exceeds WINDOW, so sum stays below 2*WINDOW
    assign sum    = acc + ACC_W'({target, 1'b0});
    assign toggle = (sum >= WIN_A);
    assign rise   = toggle && !fout;

    assign edge_nxt = edge_cnt + {{(CNT_W-1){1'b0}}, rise};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            target      <= '0;
            pending     <= '0;
            pending_vld <= 1'b0;
            sat         <= 1'b0;
        end else begin
            if (accept)
                sat <= (cfg_count > HALF);
            if (!enable) begin
                if (accept) begin
                    target <= clamped;
                end else if (pending_vld) begin
                    target      <= pending;
                    pending_vld <= 1'b0;
                end
            end else begin
                // an old pending applies here; ready is low, so no clash
                if (boundary && pending_vld) begin
                    target      <= pending;
                    pending_vld <= 1'b0;
                end
                if (accept) begin
                    pending     <= clamped;
                    pending_vld <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_cnt  <= '0;
            acc      <= '0;
            fout     <= 1'b0;
            edge_cnt <= '0;
        end else if (!enable) begin
            win_cnt  <= '0;
            acc      <= '0;
            fout     <= 1'b0;
            edge_cnt <= '0;
        end else if (boundary) begin
            win_cnt  <= '0;
            acc      <= '0;
            fout     <= 1'b0;
            edge_cnt <= '0;
        end else begin
            win_cnt  <= win_cnt + 1'b1;
            acc      <= toggle ? (sum - WIN_A) : sum;
            fout     <= fout ^ toggle;
            edge_cnt <= edge_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_last  <= '0;
            cnt_valid <= 1'b0;
        end else begin
            cnt_valid <= 1'b0;
            if (boundary) begin
                cnt_last  <= edge_nxt;
                cnt_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_freq_gen.sv
// tb_freq_gen: directed checks of freq_gen with WINDOW=100, including a
// negedge-sampled edge meter aligned to win_start.
module tb_freq_gen;

    localparam int WIN   = 100;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             enable;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [CNT_W-1:0] cfg_count;
    logic             fout;
    logic             win_start;
    logic [CNT_W-1:0] cnt_last;
    logic             cnt_valid;
    logic             sat;

    int n_tests = 0;
    int n_fail  = 0;

    freq_gen #(
        .WINDOW(WIN),
        .CNT_W (CNT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_count(cfg_count),
        .fout     (fout),
        .win_start(win_start),
        .cnt_last (cnt_last),
        .cnt_valid(cnt_valid),
        .sat      (sat)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_ws();
        int n = 0;
        do begin
            tick();
            n++;
        end while (!win_start && n < 3 * WIN);
        if (!win_start)
            check("ws_timeout", 0, 1);
    endtask

    task automatic offer(input int v);
        cfg_valid = 1'b1;
        cfg_count = CNT_W'(v);
        tick();
        cfg_valid = 1'b0;
    endtask

    // call at a win_start sample; ends at the next win_start sample
    task automatic measure(input int exp, output int rises,
                           output int gmin, output int gmax,
                           output int highs);
        int prev;
        int last;
        check("ws_fout0", int'(fout), 0);
        rises = 0;
        highs = int'(fout);
        prev  = int'(fout);
        last  = -1;
        gmin  = 1000;
        gmax  = 0;
        for (int i = 1; i < WIN; i++) begin
            tick();
            if (fout && prev == 0) begin
                if (last >= 0) begin
                    if (i - last < gmin) gmin = i - last;
                    if (i - last > gmax) gmax = i - last;
                end
                last = i;
                rises++;
            end
            highs += int'(fout);
            prev = int'(fout);
        end
        tick();
        check("ws_period", int'(win_start), 1);
        check("cnt_valid", int'(cnt_valid), 1);
        check("cnt_last", int'(cnt_last), exp);
        check("meter", rises, exp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r, gmin, gmax, hi, n, cv_seen;
        rst_n     = 1'b0;
        enable    = 1'b0;
        cfg_valid = 1'b0;
        cfg_count = '0;
        #12;
        check("rst_fout", int'(fout), 0);
        check("rst_ready", int'(cfg_ready), 1);
        check("rst_cnt_last", int'(cnt_last), 0);
        check("rst_cnt_valid", int'(cnt_valid), 0);
        check("rst_sat", int'(sat), 0);
        check("rst_ws", int'(win_start), 0);
        tick();
        rst_n = 1'b1;
        tick();

        // load 10 while idle, then run
        offer(10);
        check("idle_sat", int'(sat), 0);
        check("idle_ready", int'(cfg_ready), 1);
        enable = 1'b1;
        #1;
        check("first_ws", int'(win_start), 1);
        wait_ws();
        check("w1_cv", int'(cnt_valid), 1);
        check("w1_cnt", int'(cnt_last), 10);
        measure(10, r, gmin, gmax, hi);
        check("t10_gmin", gmin, 10);
        check("t10_gmax", gmax, 10);
        check("t10_high", hi, 50);

        // mid-window offer goes to pending; second offer stalls
        for (int i = 0; i < 30; i++) tick();
        cfg_valid = 1'b1;
        cfg_count = 16'd20;
        check("hs_ready", int'(cfg_ready), 1);
        tick();
        cfg_count = 16'd30;
        check("hs_busy", int'(cfg_ready), 0);
        n = 0;
        do begin
            tick();
            n++;
        end while (!cfg_ready && n < 3 * WIN);
        check("stall_ready", int'(cfg_ready), 1);
        check("stall_at_ws", int'(win_start), 1);
        check("stall_cnt", int'(cnt_last), 10);
        tick();
        cfg_valid = 1'b0;
        check("hs2_busy", int'(cfg_ready), 0);
        wait_ws();
        check("w20_cnt", int'(cnt_last), 20);
        offer(7);
        wait_ws();
        check("w30_cnt", int'(cnt_last), 30);
        measure(7, r, gmin, gmax, hi);
        check("t7_gmin", gmin, 14);
        check("t7_gmax", gmax, 15);

        // drop enable at win_cnt=57
        for (int i = 0; i < 57; i++) tick();
        enable = 1'b0;
        tick();
        check("dis_fout", int'(fout), 0);
        check("dis_ws", int'(win_start), 0);
        check("dis_cnt", int'(cnt_last), 7);
        cv_seen = int'(cnt_valid);
        for (int i = 0; i < 5; i++) begin
            tick();
            cv_seen += int'(cnt_valid);
        end
        check("dis_cv", cv_seen, 0);
        check("dis_hold", int'(cnt_last), 7);
        enable = 1'b1;
        #1;
        check("reen_ws", int'(win_start), 1);
        wait_ws();
        check("reen_cv", int'(cnt_valid), 1);
        check("reen_cnt", int'(cnt_last), 7);

        // clamp to WINDOW/2, then load 0
        enable = 1'b0;
        tick();
        offer(60);
        check("sat_set", int'(sat), 1);
        check("sat_ready", int'(cfg_ready), 1);
        enable = 1'b1;
        wait_ws();
        measure(50, r, gmin, gmax, hi);
        check("t50_gmin", gmin, 2);
        check("t50_gmax", gmax, 2);
        check("t50_high", hi, 50);
        offer(0);
        check("sat_clr", int'(sat), 0);
        check("zero_pend", int'(cfg_ready), 0);
        wait_ws();
        check("w50_cnt", int'(cnt_last), 50);
        measure(0, r, gmin, gmax, hi);
        check("t0_high", hi, 0);

        // async reset mid-window with a pending value
        offer(70);
        wait_ws();
        wait_ws();
        check("w70_cnt", int'(cnt_last), 50);
        for (int i = 0; i < 20; i++) tick();
        offer(80);
        check("pre_rst_ready", int'(cfg_ready), 0);
        check("pre_rst_sat", int'(sat), 1);
        n = 0;
        while (!fout && n < 4) begin
            tick();
            n++;
        end
        check("pre_rst_fout", int'(fout), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_fout", int'(fout), 0);
        check("arst_ready", int'(cfg_ready), 1);
        check("arst_sat", int'(sat), 0);
        check("arst_cnt", int'(cnt_last), 0);
        check("arst_cv", int'(cnt_valid), 0);
        tick();
        rst_n = 1'b1;
        wait_ws();
        check("post_rst_cnt", int'(cnt_last), 0);
        check("post_rst_ready", int'(cfg_ready), 1);
        measure(0, r, gmin, gmax, hi);
        check("post_rst_high", hi, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
